// File: rtl/vga_text_pkg.sv
// Package vga_text_pkg: geometry, blank code, control codes and the FSM
// state type shared by the VGA text console and its bench.
package vga_text_pkg;

    localparam int unsigned COLS   = 50;   // characters per row (400 px / 8)
    localparam int unsigned ROWS   = 30;   // character rows (600 lines / 2 / 10)
    localparam int unsigned CELLS  = COLS * ROWS;

    localparam int unsigned COL_W  = 6;    // holds 0..COLS-1
    localparam int unsigned ROW_W  = 5;    // holds 0..ROWS-1
    localparam int unsigned ADDR_W = 11;   // holds 0..CELLS-1

    localparam logic [6:0] BLANK_CHAR = 7'h20;

    localparam logic [6:0] CH_BS  = 7'h08;
    localparam logic [6:0] CH_TAB = 7'h09;
    localparam logic [6:0] CH_LF  = 7'h0A;
    localparam logic [6:0] CH_FF  = 7'h0C;
    localparam logic [6:0] CH_CR  = 7'h0D;

    typedef enum logic [2:0] {
        CLR_SCREEN,
        IDLE,
        WRITE,
        CLR_LINE,
        TAB
    } console_state_t;

    // Codes that land in a cell as-is: space through tilde.
    function automatic logic is_printable(input logic [6:0] code);
        return (code >= 7'h20) && (code <= 7'h7E);
    endfunction

endpackage

// File: rtl/vga_text_console_if.sv
// Character stream (valid/ready) plus display-buffer write port.
// master: character source and adapter side; slave: the console.
interface vga_text_console_if;

    logic [6:0]  char_in;
    logic        char_valid;
    logic        char_ready;
    logic [10:0] address;
    logic [6:0]  char_output;
    logic        write_enable;

    modport master (
        output char_in, char_valid,
        input  char_ready, address, char_output, write_enable
    );

    modport slave (
        input  char_in, char_valid,
        output char_ready, address, char_output, write_enable
    );

endinterface

// File: rtl/vga_text_console.sv
// vga_text_console: terminal-style write controller for the 50x30 text
// buffer. Tracks the cursor, decodes LF/CR/BS/FF, clears lines on advance,
// and is the sole writer of the buffer (one cell per cycle).
// Build option: define TAB_EXPAND_EN to expand 0x09 to blanks up to the
// next multiple-of-8 column; otherwise 0x09 is accepted and dropped.
module vga_text_console
    import vga_text_pkg::*;
(
    input  logic               clk_20_mhz,
    input  logic               reset_n,
    vga_text_console_if.slave  bus,
    output logic [COL_W-1:0]   cursor_col,
    output logic [ROW_W-1:0]   cursor_row,
    output logic               busy
);

    localparam logic [COL_W-1:0]  LAST_COL       = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW       = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL      = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] LAST_LINE_CELL = ADDR_W'(COLS - 1);

    console_state_t    state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [ADDR_W-1:0] line_base_q, line_base_d;   // row*COLS, kept by accumulation
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;       // cell index within a clear run
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [6:0]        char_q, char_d;
    logic              we_q, we_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              advance;

    // Next state, counters and registered outputs of the console FSM.
    always_comb begin
        // NOTE: every _d first takes a default so no path leaves it unassigned and no latch is inferred.
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        line_base_d = line_base_q;
        clr_cnt_d   = clr_cnt_q;
        addr_d      = addr_q;
        char_d      = char_q;
        we_d        = 1'b0;
        advance     = 1'b0;

        case (state_q)
            CLR_SCREEN: begin
                we_d   = 1'b1;
                addr_d = clr_cnt_q;
                char_d = BLANK_CHAR;
                if (clr_cnt_q == LAST_CELL) begin
                    state_d     = IDLE;
                    clr_cnt_d   = '0;
                    col_d       = '0;
                    row_d       = '0;
                    line_base_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end

            IDLE: begin
                if (bus.char_valid && ready_q) begin
                    if (is_printable(bus.char_in)) begin
                        we_d   = 1'b1;
                        addr_d = line_base_q + ADDR_W'(col_q);
                        char_d = bus.char_in;
                        if (col_q == LAST_COL) begin
                            advance = 1'b1;
                        end else begin
                            col_d   = col_q + COL_W'(1);
                            state_d = WRITE;
                        end
                    end else begin
                        case (bus.char_in)
                            CH_LF: advance = 1'b1;
                            CH_CR: col_d = '0;
                            CH_BS: begin
                                if (col_q != '0) begin
                                    col_d   = col_q - COL_W'(1);
                                    we_d    = 1'b1;
                                    addr_d  = line_base_q + ADDR_W'(col_q - COL_W'(1));
                                    char_d  = BLANK_CHAR;
                                    state_d = WRITE;
                                end
                            end
                            CH_FF: begin
                                state_d   = CLR_SCREEN;
                                clr_cnt_d = '0;
                            end
`ifdef TAB_EXPAND_EN
                            CH_TAB: state_d = TAB;
`endif
                            default: ;  // other codes are consumed without effect
                        endcase
                    end
                end
            end

            // The cell write was issued on acceptance; this cycle only waits for it.
            WRITE: state_d = IDLE;

            CLR_LINE: begin
                we_d   = 1'b1;
                addr_d = line_base_q + clr_cnt_q;
                char_d = BLANK_CHAR;
                if (clr_cnt_q == LAST_LINE_CELL) begin
                    state_d   = IDLE;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + ADDR_W'(1);
                end
            end

`ifdef TAB_EXPAND_EN
            TAB: begin
                we_d   = 1'b1;
                addr_d = line_base_q + ADDR_W'(col_q);
                char_d = BLANK_CHAR;
                if (col_q == LAST_COL) begin
                    advance = 1'b1;
                end else begin
                    col_d = col_q + COL_W'(1);
                    if (col_q[2:0] == 3'd7) begin
                        state_d = IDLE;
                    end
                end
            end
`endif

            default: begin
                state_d   = CLR_SCREEN;
                clr_cnt_d = '0;
            end
        endcase

        // Advance-line: home the column, step or wrap the row, clear the new row.
        if (advance) begin
            col_d     = '0;
            clr_cnt_d = '0;
            state_d   = CLR_LINE;
            if (row_q == LAST_ROW) begin
                row_d       = '0;
                line_base_d = '0;
            end else begin
                row_d       = row_q + ROW_W'(1);
                line_base_d = line_base_q + ADDR_W'(COLS);
            end
        end

        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers; a low reset_n restarts the full-screen clear.
    always_ff @(posedge clk_20_mhz) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q     <= CLR_SCREEN;
            col_q       <= '0;
            row_q       <= '0;
            line_base_q <= '0;
            clr_cnt_q   <= '0;
            addr_q      <= '0;
            char_q      <= BLANK_CHAR;
            we_q        <= 1'b0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            line_base_q <= line_base_d;
            clr_cnt_q   <= clr_cnt_d;
            addr_q      <= addr_d;
            char_q      <= char_d;
            we_q        <= we_d;
            ready_q     <= ready_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.char_ready   = ready_q;
    assign bus.address      = addr_q;
    assign bus.char_output  = char_q;
    assign bus.write_enable = we_q;
    assign cursor_col       = col_q;
    assign cursor_row       = row_q;
    assign busy             = busy_q;

endmodule
